// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

    // Width of the source-index tag carried on d_out when tagging is enabled.
    function automatic int unsigned tag_width(input int unsigned n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping N-1 -> 0.
module rr_pick import fifo_arb_pkg::*; #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          any_req
);

    int idx;

    // Walk offsets from highest to lowest so the smallest offset wins.
    always_comb begin
        pick = '0;
        idx  = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= int'(N)) idx = idx - int'(N);
            if (req[idx]) pick = N'(1) << idx;
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N req/ack channels with bounded bursts.
// Define FIFO_WR_ARB_TAG_EN to append the granted index above the data on d_out.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
    parameter int unsigned dw    = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned BURST = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N-1:0]          req_in,
    input  logic [N*dw-1:0]       d_in,
    output logic [N-1:0]          ack_in,
`ifdef FIFO_WR_ARB_TAG_EN
    output logic [dw+tag_width(N)-1:0] d_out,
`else
    output logic [dw-1:0]         d_out,
`endif
    output logic                  req_out,
    input  logic                  ack_out,
    output logic [N-1:0]          gnt,
    output logic                  busy
);

    localparam int unsigned   PW   = clog2(N);
    localparam int unsigned   CW   = clog2(BURST) + 1;
    localparam logic [CW-1:0] LAST = CW'(BURST - 1);
    localparam logic [PW-1:0] PMAX = PW'(N - 1);

    arb_state_e    state_q;
    logic [N-1:0]  gnt_q;
    logic [PW-1:0] gidx_q;
    logic [PW-1:0] ptr_q;
    logic [CW-1:0] count_q;

    logic [N-1:0]  pick;
    logic          any_req;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] next_ptr;
    logic          req_g;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req     (req_in),
        .ptr     (ptr_q),
        .pick    (pick),
        .any_req (any_req)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (pick[i]) pick_idx = PW'(i);
        end
    end

    assign next_ptr = (gidx_q == PMAX) ? '0 : gidx_q + PW'(1);
    assign req_g    = req_in[gidx_q];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= GRANT;
                        gnt_q   <= pick;
                        gidx_q  <= pick_idx;
                        count_q <= '0;
                    end
                end
                GRANT: begin
                    // Dropped request or final transfer of the burst both hand the pointer on.
                    if (!req_g || (ack_out && count_q == LAST)) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        ptr_q   <= next_ptr;
                    end else if (ack_out) begin
                        count_q <= count_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_out = 1'b0;
        ack_in  = '0;
        d_out   = '0;
        if (state_q == GRANT) begin
            req_out          = req_g;
            ack_in           = gnt_q & {N{ack_out}};
            d_out[dw-1:0]    = d_in[int'(gidx_q)*dw +: dw];
`ifdef FIFO_WR_ARB_TAG_EN
            d_out[dw +: PW]  = gidx_q;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q == GRANT);

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares one FIFO write port among N requesters, each with its own req/ack/data channel.
- Grants one requester at a time using round-robin, and holds the grant for a bounded burst.
- Routes the granted channel to the FIFO input handshake (req_out/ack_out → FIFO req_in/ack_in).
- Sits between the producer blocks and the FIFO instance in the datapath.

Parameters:
- dw, 8, data width per channel and at the output.
- N, 4, number of requesters (2..8).
- BURST, 4, maximum transfers per grant before forced re-arbitration (>=1).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_in  in  N  per-requester valid.
- d_in  in  N*dw  flattened data; channel i occupies bits [i*dw +: dw].
- ack_in  out  N  per-requester accept.
- d_out  out  dw  data to FIFO.
- req_out  out  1  valid to FIFO.
- ack_out  in  1  FIFO accept (FIFO not full).
- gnt  out  N  one-hot current grant; all zero when idle.
- busy  out  1  high while in GRANT.

Behaviour:
- Transfer rule: a transfer occurs on a channel when req & ack are both high at a rising clk edge. There is no other transfer condition.
- Reset state: IDLE, gnt=0, burst count=0, rr pointer=0.
- Outputs during reset: req_out=0, ack_in=0, d_out=0, busy=0.
- States: IDLE, GRANT. Encoding is taken from the package.
- IDLE:
  - All outputs are zero.
  - If req_in≠0, pick the first set bit searching upward from the rr pointer, wrapping N-1→0.
  - Register that pick into gnt, set count=0, go to GRANT.
  - If req_in=0, stay in IDLE.
- GRANT (grant index g):
  - req_out=req_in[g], d_out=d_in[g], ack_in[g]=ack_out.
  - All other ack_in bits are 0.
- Grant latency:
  - One cycle from req_in rising in IDLE to gnt valid.
  - No combinational path from req_in to ack_in in IDLE, so the arbiter is non-transparent.
- Burst accounting:
  - Each transfer on g increments count.
  - A transfer with count==BURST-1 ends the grant: next state IDLE, rr pointer=g+1 mod N.
- Early release:
  - If req_in[g]=0 in GRANT, go to IDLE next cycle with rr pointer=g+1 mod N.
  - No transfer occurs that cycle.
- FIFO full (ack_out=0): the grant is held, count is unchanged, req_out reflects req_in[g]. There is no timeout.
- Re-arbitration costs exactly one IDLE cycle. Sustained throughput for a single requester is BURST/(BURST+1).
- Fairness: with all N requesting continuously, grants rotate 0,1,…,N-1,0. No requester waits more than (N-1)*(BURST+1) cycles once its req is high.
- Simultaneous early release and last transfer are impossible, since a transfer needs req high. The last transfer takes precedence over any future drop.
- Requester protocol: a requester must hold d_in stable while req is high and not yet acked. The arbiter does not check this.
- Reset mid-burst: immediately (asynchronously) return to IDLE; all outputs go to 0; any in-flight transfer is lost.
- Width rules:
  - count width = clog2(BURST)+1.
  - pointer width = clog2(N), with an explicit wrap at N-1.

Optional Feature:
- Macro: FIFO_WR_ARB_TAG_EN.
- Defined:
  - d_out widens to dw+clog2(N).
  - The upper clog2(N) bits carry the granted index g, so the consumer can identify the source. This field is 0 in IDLE.
- Undefined: d_out is exactly dw bits; no tag.
- The downstream FIFO dw parameter must match the resulting width.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, GRANT};
  - localparam function for clog2;
  - tag-width constant derived from N.
- Sub-module rr_pick: purely combinational.
  - Inputs: req vector and pointer.
  - Outputs: one-hot pick and an any_req flag.
- fifo_wr_arbiter instantiates rr_pick once and holds the FSM, counter, pointer and muxes.

Test Plan:
- Single requester, N=4, BURST=4, ack_out=1:
  - req_in=0001 held for 10 cycles.
  - Expect gnt=0001 one cycle later, then 4 transfers, 1 IDLE cycle, re-grant to 0001.
- All requesting, ack_out=1, 24 cycles:
  - Expect grant order 0,1,2,3,0.
  - Expect 4 transfers each, data matching the source channel.
  - Expect an IDLE cycle between grants.
- FIFO full:
  - Granted to ch2 after 2 transfers, ack_out=0 for 5 cycles.
  - Expect gnt held, ack_in=0000, count stays 2.
  - After ack_out=1, expect exactly 2 more transfers.
- Early release:
  - ch1 drops req after 1 transfer while ch3 requests.
  - Expect IDLE next cycle, then gnt=1000 (ch3).
- Async reset mid-burst:
  - rstn low between edges during a ch0 burst.
  - Expect gnt, req_out, ack_in and busy at 0 immediately.
  - After release with req_in=0010, expect the first grant to ch1 (pointer=0).
- FIFO_WR_ARB_TAG_EN defined, ch3 sends 8'hA5:
  - Expect d_out=10'b11_10100101.
